// File: rtl/dht11_onewire_rx.sv
// DHT11 single-wire protocol engine: issues the host start pulse, decodes the 40-bit
// sensor frame from pulse widths, checks the checksum and reports done/error status.
module dht11_onewire_rx #(
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned RELEASE_US    = 30,
    parameter int unsigned BIT_THRESH_US = 40,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned CNT_W         = 15
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        i_tick_1us,
    input  logic        i_start,
    inout  wire         dht_io,
    output logic [39:0] o_data,
    output logic        o_done,
    output logic        o_chk_ok,
    output logic        o_err,
    output logic        o_busy,
    output logic [3:0]  o_state
);

    localparam int unsigned FRAME_W = 40;
    localparam int unsigned IDX_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_RELEASE   = 4'd2,
        S_RESP_LOW  = 4'd3,
        S_RESP_HIGH = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_DONE      = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [FRAME_W-1:0]   shift_q;
    logic [1:0]           sync_q;
    logic                 line_q;
    logic                 rise_q;
    logic                 fall_q;
    logic                 start_q;
    logic                 drive_q;
    logic                 busy_q;
    logic                 start_rise_c;
    logic                 timeout_c;
    logic [7:0]           sum_c;

    // Open-drain: only ever pull low or release
    assign dht_io = drive_q ? 1'b0 : 1'bz;

    assign start_rise_c = i_start & ~start_q;
    assign timeout_c    = (cnt >= CNT_W'(TIMEOUT_US));
    assign sum_c        = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    assign o_state      = state;
    assign o_busy       = busy_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge events take priority over timeout in the sensor-driven states
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_rise_c) state_nxt = S_START;
            S_START:     if (cnt == CNT_W'(START_LOW_US)) state_nxt = S_RELEASE;
            S_RELEASE:   if (cnt == CNT_W'(RELEASE_US)) state_nxt = S_RESP_LOW;
            S_RESP_LOW:  if (rise_q) state_nxt = S_RESP_HIGH;
                         else if (timeout_c) state_nxt = S_ERROR;
            S_RESP_HIGH: if (fall_q) state_nxt = S_BIT_LOW;
                         else if (timeout_c) state_nxt = S_ERROR;
            S_BIT_LOW:   if (rise_q) state_nxt = S_BIT_HIGH;
                         else if (timeout_c) state_nxt = S_ERROR;
            S_BIT_HIGH:  if (fall_q) state_nxt = (bit_idx == IDX_W'(FRAME_W - 1)) ? S_DONE : S_BIT_LOW;
                         else if (timeout_c) state_nxt = S_ERROR;
            S_DONE:      state_nxt = S_IDLE;
            S_ERROR:     state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q   <= 2'b11;
            line_q   <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            start_q  <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            drive_q  <= 1'b0;
            busy_q   <= 1'b0;
            o_data   <= '0;
            o_done   <= 1'b0;
            o_chk_ok <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], dht_io};
            line_q  <= sync_q[1];
            rise_q  <= sync_q[1] & ~line_q;
            fall_q  <= ~sync_q[1] & line_q;
            start_q <= i_start;
            drive_q <= (state_nxt == S_START);
            busy_q  <= (state_nxt != S_IDLE);
            o_done  <= 1'b0;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (i_tick_1us && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == S_IDLE && start_rise_c) begin
                o_err <= 1'b0;
            end
            if (state == S_RESP_HIGH && fall_q) begin
                bit_idx <= '0;
            end
            // High-time length decides the bit value
            if (state == S_BIT_HIGH && fall_q) begin
                shift_q <= {shift_q[FRAME_W-2:0], (cnt > CNT_W'(BIT_THRESH_US))};
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (state == S_DONE) begin
                o_data   <= shift_q;
                o_chk_ok <= (sum_c == shift_q[7:0]);
                o_done   <= 1'b1;
            end
            if (state == S_ERROR) begin
                o_err  <= 1'b1;
                o_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_onewire_rx.sv
// Directed bench for dht11_onewire_rx with a behavioural DHT11 sensor on a pulled-up line.
module tb_dht11_onewire_rx;

    localparam int unsigned START_LOW = 100;
    localparam int unsigned TICK_DIV  = 2;
    localparam int unsigned BUDGET    = 40000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        i_tick_1us = 1'b0;
    logic        i_start;
    wire         dht_io;
    logic [39:0] o_data;
    logic        o_done;
    logic        o_chk_ok;
    logic        o_err;
    logic        o_busy;
    logic [3:0]  o_state;

    logic        sen_drv = 1'b0;
    logic        sen_busy = 1'b0;
    int          sen_mode = 0;
    int          sen_stop_bit = 40;
    logic [39:0] sen_frame = '0;
    int          host_low_ticks = 0;
    int          tick_cnt = 0;

    int          n_checks = 0;
    int          n_pass = 0;

    pullup (dht_io);
    assign dht_io = sen_drv ? 1'b0 : 1'bz;

    dht11_onewire_rx #(
        .START_LOW_US (START_LOW),
        .RELEASE_US   (30),
        .BIT_THRESH_US(40),
        .TIMEOUT_US   (200),
        .CNT_W        (15)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .i_tick_1us(i_tick_1us),
        .i_start   (i_start),
        .dht_io    (dht_io),
        .o_data    (o_data),
        .o_done    (o_done),
        .o_chk_ok  (o_chk_ok),
        .o_err     (o_err),
        .o_busy    (o_busy),
        .o_state   (o_state)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        tick_cnt   <= (tick_cnt == int'(TICK_DIV) - 1) ? 0 : tick_cnt + 1;
        i_tick_1us <= (tick_cnt == int'(TICK_DIV) - 1);
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            while (!i_tick_1us) @(negedge PCLK);
        end
    endtask

    // Sensor model: answers each host start pulse according to sen_mode
    // (0 = full frame, 1 = absent, 2 = hold line low from bit sen_stop_bit)
    initial begin
        forever begin
            @(negedge PCLK);
            if (dht_io === 1'b0 && !sen_drv) begin
                sen_busy       = 1'b1;
                host_low_ticks = 0;
                while (dht_io === 1'b0) begin
                    if (i_tick_1us) host_low_ticks++;
                    @(negedge PCLK);
                end
                if (sen_mode != 1) begin
                    logic stalled;
                    stalled = 1'b0;
                    wait_ticks(20);
                    sen_drv = 1'b1;
                    wait_ticks(80);
                    sen_drv = 1'b0;
                    wait_ticks(80);
                    for (int b = 0; b < 40; b++) begin
                        if (!stalled) begin
                            sen_drv = 1'b1;
                            if (sen_mode == 2 && b == sen_stop_bit) begin
                                int cyc;
                                cyc = 0;
                                while (o_busy && cyc < 4000) begin
                                    @(negedge PCLK);
                                    cyc++;
                                end
                                stalled = 1'b1;
                            end else begin
                                wait_ticks(50);
                                sen_drv = 1'b0;
                                wait_ticks(sen_frame[39-b] ? 70 : 27);
                            end
                        end
                    end
                    sen_drv = 1'b1;
                    if (!stalled) wait_ticks(50);
                    sen_drv = 1'b0;
                end
                sen_busy = 1'b0;
            end
        end
    end

    task automatic start_frame();
        @(negedge PCLK);
        i_start = 1'b0;
        @(negedge PCLK);
        i_start = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st);
        int cyc;
        cyc = 0;
        while (o_state !== st && cyc < int'(BUDGET)) begin
            @(negedge PCLK);
            cyc++;
        end
        check(tag, 40'(o_state), 40'(st));
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (o_done !== 1'b1 && cyc < int'(BUDGET)) begin
            @(negedge PCLK);
            cyc++;
        end
        check({tag, "_done"}, 40'(o_done), 40'd1);
        check({tag, "_busy_at_done"}, 40'(o_busy), 40'd0);
        @(negedge PCLK);
        check({tag, "_done_width"}, 40'(o_done), 40'd0);
    endtask

    task automatic wait_sensor_idle();
        int cyc;
        cyc = 0;
        while (sen_busy && cyc < int'(BUDGET)) begin
            @(negedge PCLK);
            cyc++;
        end
        check("sensor_idle", 40'(sen_busy), 40'd0);
        repeat (10) @(negedge PCLK);
    endtask

    initial begin
        PRESET  = 1'b1;
        i_start = 1'b0;
        repeat (5) @(negedge PCLK);
        check("rst_state", 40'(o_state), 40'd0);
        check("rst_busy", 40'(o_busy), 40'd0);
        check("rst_data", o_data, 40'd0);
        check("rst_flags", 40'({o_done, o_chk_ok, o_err}), 40'd0);
        check("rst_line", 40'(dht_io), 40'd1);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        // Good frame
        sen_mode  = 0;
        sen_frame = 40'h2D001A0047;
        start_frame();
        repeat (3) @(negedge PCLK);
        check("t1_state_start", 40'(o_state), 40'd1);
        check("t1_busy", 40'(o_busy), 40'd1);
        check("t1_line_low", 40'(dht_io), 40'd0);
        wait_done("t1");
        check("t1_host_low_ticks", 40'(host_low_ticks), 40'(START_LOW));
        check("t1_data", o_data, 40'h2D001A0047);
        check("t1_chk", 40'(o_chk_ok), 40'd1);
        check("t1_err", 40'(o_err), 40'd0);
        wait_sensor_idle();

        // Bad checksum
        sen_frame = 40'h2D001A0048;
        start_frame();
        wait_done("t2");
        check("t2_data", o_data, 40'h2D001A0048);
        check("t2_chk", 40'(o_chk_ok), 40'd0);
        check("t2_err", 40'(o_err), 40'd0);
        wait_sensor_idle();

        // Sensor absent
        sen_mode = 1;
        start_frame();
        wait_state("t3_resp_low", 4'd3);
        wait_done("t3");
        check("t3_err", 40'(o_err), 40'd1);
        check("t3_data_held", o_data, 40'h2D001A0048);
        check("t3_chk_held", 40'(o_chk_ok), 40'd0);
        wait_sensor_idle();

        // Sensor stalls low mid-frame
        sen_mode     = 2;
        sen_stop_bit = 13;
        sen_frame    = 40'h2D001A0047;
        start_frame();
        wait_done("t4");
        check("t4_err", 40'(o_err), 40'd1);
        check("t4_data_held", o_data, 40'h2D001A0048);
        wait_sensor_idle();

        // Extra start edge while busy is ignored
        sen_mode = 0;
        start_frame();
        repeat (3) @(negedge PCLK);
        check("t5_err_cleared", 40'(o_err), 40'd0);
        wait_state("t5_bit_low", 4'd5);
        i_start = 1'b0;
        @(negedge PCLK);
        i_start = 1'b1;
        wait_done("t5");
        check("t5_data", o_data, 40'h2D001A0047);
        check("t5_chk", 40'(o_chk_ok), 40'd1);
        check("t5_err", 40'(o_err), 40'd0);
        repeat (100) @(negedge PCLK);
        check("t5_no_retrigger", 40'(o_busy), 40'd0);
        wait_sensor_idle();

        // Reset during BIT_HIGH
        sen_frame = 40'h3C05190A64;
        start_frame();
        repeat (3) @(negedge PCLK);
        i_start = 1'b0;
        wait_state("t6_bit_high", 4'd6);
        repeat (5) @(negedge PCLK);
        check("t6_still_bit_high", 40'(o_state), 40'd6);
        PRESET = 1'b1;
        #1;
        check("t6_rst_busy", 40'(o_busy), 40'd0);
        check("t6_rst_state", 40'(o_state), 40'd0);
        check("t6_rst_line", 40'(dht_io), 40'd1);
        @(negedge PCLK);
        PRESET = 1'b0;
        wait_sensor_idle();
        check("t6_rst_data", o_data, 40'd0);
        check("t6_idle_after_rst", 40'(o_busy), 40'd0);
        start_frame();
        wait_done("t6");
        check("t6_data", o_data, 40'h3C05190A64);
        check("t6_chk", 40'(o_chk_ok), 40'd1);
        check("t6_err", 40'(o_err), 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
